// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the uart_tx arbiter.
//   arb_state_t : arbiter FSM states
//   CNT_W       : width of the completed-byte counter
//   MAX_REQ     : widest requester vector rr_next() accepts
//   rr_next()   : round-robin successor, first held index after 'last' modulo n_req
package uart_arb_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        GAP       = 3'd4
    } arb_state_t;

    localparam int CNT_W   = 16;
    localparam int MAX_REQ = 32;

    // Returns 'last' unchanged when nothing is held.
    function automatic int unsigned rr_next(input logic [MAX_REQ-1:0] held,
                                            input int unsigned        last,
                                            input int unsigned        n_req);
        int unsigned idx;
        for (int unsigned k = 1; k <= n_req; k++) begin
            idx = (last + k) % n_req;
            if (held[idx[4:0]]) return idx;
        end
        return last;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational choice of the next requester to serve.
//   held_i : occupied hold slots
//   last_i : requester served last (round-robin pointer)
//   pick_o : index to grant; slot 0 overrides when PRIO0 is set
//   any_o  : at least one slot is occupied
module rr_priority_pick
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int PRIO0 = 1,
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] held_i,
    input  logic [ID_W-1:0]  last_i,
    output logic [ID_W-1:0]  pick_o,
    output logic             any_o
);

    logic [ID_W-1:0] idx;
    logic            found;

    always_comb begin
        pick_o = last_i;
        found  = 1'b0;
        idx    = '0;
        // Scan starting one past the last grant so the last winner goes to the back.
        for (int k = 1; k <= N_REQ; k++) begin
            idx = ID_W'((int'(last_i) + k) % N_REQ);
            if (!found && held_i[idx]) begin
                pick_o = idx;
                found  = 1'b1;
            end
        end
        if (PRIO0 != 0 && held_i[0]) begin
            pick_o = '0;
        end
        any_o = |held_i;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx serialiser between N_REQ byte requesters. Each requester
// owns a single-byte hold slot; the arbiter grants the link by fixed priority
// (slot 0) and/or round robin, then walks the byte through uart_tx's
// valid / tx_ready handshake, with an optional inter-byte gap and a sticky
// flag for a serialiser that never went busy.
//   clk, reset   : system clock, asynchronous active-high reset
//   req_valid    : requester i offers req_data[i*DATA_W +: DATA_W]
//   req_ready    : slot i empty; byte taken on valid & ready
//   uart_data    : byte presented to uart_tx
//   uart_valid   : one-cycle start pulse to uart_tx
//   uart_ready   : uart_tx idle
//   grant_id     : requester currently or last served
//   busy         : FSM away from IDLE
//   timeout_err  : sticky, uart_tx never dropped ready after a pulse
//   sent_count   : bytes completed, wraps
//
// state     | meaning
// IDLE      | waiting for a held byte and an idle serialiser
// ISSUE     | uart_valid high for this single cycle, slot released
// WAIT_BUSY | waiting for uart_ready to fall, bounded by BUSY_TIMEOUT
// WAIT_DONE | frame on the wire, waiting for uart_ready to rise
// GAP       | GAP_CYCLES idle cycles before the next grant
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ        = 3,
    parameter int DATA_W       = 8,
    parameter int PRIO0        = 1,
    parameter int GAP_CYCLES   = 0,
    parameter int BUSY_TIMEOUT = 64,
    localparam int ID_W        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]       uart_data,
    output logic                    uart_valid,
    input  logic                    uart_ready,
    output logic [ID_W-1:0]         grant_id,
    output logic                    busy,
    output logic                    timeout_err,
    output logic [CNT_W-1:0]        sent_count
);

    localparam int TMR_MAX  = (BUSY_TIMEOUT > GAP_CYCLES) ? BUSY_TIMEOUT : GAP_CYCLES;
    localparam int TMR_W    = $clog2(TMR_MAX + 1);
    localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    // With no gap configured the byte's end goes straight back to IDLE.
    localparam arb_state_t POST_STATE = (GAP_CYCLES == 0) ? IDLE : GAP;

    arb_state_t          state_q, state_d;
    logic [N_REQ-1:0]    held_q, held_d;
    logic [DATA_W-1:0]   slot_q [N_REQ];
    logic [DATA_W-1:0]   uart_data_q, uart_data_d;
    logic [ID_W-1:0]     grant_q, grant_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic                timeout_q, timeout_d;
    logic [CNT_W-1:0]    sent_q, sent_d;
    logic [N_REQ-1:0]    load;
    logic [ID_W-1:0]     pick_id;
    logic                pick_any;

    assign req_ready = ~held_q;
    assign load      = req_valid & req_ready;

    rr_priority_pick #(
        .N_REQ (N_REQ),
        .PRIO0 (PRIO0)
    ) u_pick (
        .held_i (held_q),
        .last_i (grant_q),
        .pick_o (pick_id),
        .any_o  (pick_any)
    );

    // The granted slot stays held through ISSUE, so a load can never collide
    // with its release; the requester may refill it the following cycle.
    always_comb begin
        held_d = held_q | load;
        if (state_q == ISSUE) begin
            held_d[grant_q] = 1'b0;
        end
    end

    always_comb begin
        state_d     = state_q;
        uart_data_d = uart_data_q;
        grant_d     = grant_q;
        timer_d     = timer_q;
        timeout_d   = timeout_q;
        sent_d      = sent_q;
        uart_valid  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_any && uart_ready) begin
                    grant_d     = pick_id;
                    uart_data_d = slot_q[pick_id];
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                uart_valid = 1'b1;
                timer_d    = TMR_W'(BUSY_TIMEOUT - 1);
                state_d    = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!uart_ready) begin
                    state_d = WAIT_DONE;
                end else if (timer_q == '0) begin
                    // Serialiser ignored the pulse: drop the byte, keep going.
                    timeout_d = 1'b1;
                    timer_d   = TMR_W'(GAP_LOAD);
                    state_d   = POST_STATE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            WAIT_DONE: begin
                if (uart_ready) begin
                    sent_d  = sent_q + CNT_W'(1);
                    timer_d = TMR_W'(GAP_LOAD);
                    state_d = POST_STATE;
                end
            end
            GAP: begin
                if (timer_q == '0) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            held_q      <= '0;
            uart_data_q <= '0;
            grant_q     <= ID_W'(N_REQ - 1);
            timer_q     <= '0;
            timeout_q   <= 1'b0;
            sent_q      <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            held_q      <= held_d;
            uart_data_q <= uart_data_d;
            grant_q     <= grant_d;
            timer_q     <= timer_d;
            timeout_q   <= timeout_d;
            sent_q      <= sent_d;
            for (int i = 0; i < N_REQ; i++) begin
                if (load[i]) begin
                    slot_q[i] <= req_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign uart_data   = uart_data_q;
    assign grant_id    = grant_q;
    assign busy        = (state_q != IDLE);
    assign timeout_err = timeout_q;
    assign sent_count  = sent_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Two arbiters side by side: index 0 has PRIO0=1, GAP=0; index 1 has PRIO0=0, GAP=5.
// Each has its own reset and a uart_tx stand-in that goes busy for 10 cycles
// after every valid pulse (or ignores pulses when 'stuck').
module tb_uart_tx_arbiter;
    import uart_arb_pkg::*;

    localparam int N     = 3;
    localparam int W     = 8;
    localparam int TO    = 64;
    localparam int UBUSY = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]     rst, stuck, hold, uart_valid, uart_ready, busy, terr;
    logic [N-1:0]   req_valid  [2];
    logic [N*W-1:0] req_data   [2];
    logic [N-1:0]   req_ready  [2];
    logic [W-1:0]   uart_data  [2];
    logic [1:0]     grant_id   [2];
    logic [15:0]    sent_count [2];

    int checks   = 0;
    int failures = 0;
    int exp_q [2][$];   // id*256 + data, in expected issue order
    int m_last [2];
    int m_sent [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        int ubusy = 0;
        uart_tx_arbiter #(
            .N_REQ        (N),
            .DATA_W       (W),
            .PRIO0        ((g == 0) ? 1 : 0),
            .GAP_CYCLES   ((g == 0) ? 0 : 5),
            .BUSY_TIMEOUT (TO)
        ) dut (
            .clk         (clk),
            .reset       (rst[g]),
            .req_valid   (req_valid[g]),
            .req_data    (req_data[g]),
            .req_ready   (req_ready[g]),
            .uart_data   (uart_data[g]),
            .uart_valid  (uart_valid[g]),
            .uart_ready  (uart_ready[g]),
            .grant_id    (grant_id[g]),
            .busy        (busy[g]),
            .timeout_err (terr[g]),
            .sent_count  (sent_count[g])
        );
        always @(posedge clk) begin
            if (uart_valid[g] && !stuck[g]) ubusy <= UBUSY;
            else if (ubusy > 0)             ubusy <= ubusy - 1;
        end
        assign uart_ready[g] = (ubusy == 0) && !hold[g];
    end

    function automatic int gapc(input int b);
        return (b == 0) ? 0 : 5;
    endfunction

    task automatic check(input string name, input int b, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[dut%0d]: got %0h expected %0h at %0t", name, b, act, exp, $time);
        end
    endtask

    // Reference arbitration: slot 0 first when prioritised, else round robin.
    function automatic int model_pick(input int b, input bit [N-1:0] pend);
        if (b == 0 && pend[0]) return 0;
        return int'(rr_next(32'(pend), m_last[b], N));
    endfunction

    task automatic model_issue(input int b, input int id, input logic [W-1:0] d, input bit completes);
        exp_q[b].push_back(id * 256 + int'(d));
        m_last[b] = id;
        if (completes) m_sent[b]++;
    endtask

    task automatic model_drain(input int b, input bit [N-1:0] pend_in, input logic [N*W-1:0] data);
        bit [N-1:0] pend = pend_in;
        int id;
        while (pend != 0) begin
            id = model_pick(b, pend);
            model_issue(b, id, data[id*W +: W], 1'b1);
            pend[id] = 1'b0;
        end
    endtask

    task automatic wait_idle(input int b);
        int n = 0;
        @(negedge clk);
        while ((exp_q[b].size() != 0 || busy[b] || !uart_ready[b]) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("drain_in_budget", b, 32'(n < 2000), 1);
    endtask

    task automatic wait_valid(input int b);
        int n = 0;
        while (!uart_valid[b] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("valid_in_budget", b, 32'(uart_valid[b]), 1);
    endtask

    // Load a set of slots while the serialiser looks busy, so the whole set is
    // held before the first grant and the issue order is fully determined.
    task automatic run_batch(input int b, input bit [N-1:0] mask, input logic [N*W-1:0] data);
        wait_idle(b);
        check("ready_before_load", b, 32'(req_ready[b]), 7);
        hold[b]      = 1'b1;
        req_valid[b] = mask;
        req_data[b]  = data;
        @(negedge clk);
        req_valid[b] = '0;
        model_drain(b, mask, data);
        hold[b] = 1'b0;
        wait_idle(b);
        check("sent_count", b, 32'(sent_count[b]), 32'(m_sent[b] & 'hFFFF));
    endtask

    // Monitor: pops one expectation per uart_valid pulse; also measures the idle
    // cycles between uart_ready rising at the end of a frame and the next pulse
    // when the next byte was already waiting (GAP_CYCLES plus the grant cycle).
    int  samp      [2];
    int  rise_at   [2];
    bit  armed     [2];
    bit  prev_rdy  [2];
    bit  prev_vld  [2];
    initial for (int b = 0; b < 2; b++) begin
        samp[b] = 0; rise_at[b] = 0; armed[b] = 0; prev_rdy[b] = 1; prev_vld[b] = 0;
    end

    always @(negedge clk) begin
        for (int b = 0; b < 2; b++) begin
            int e;
            if (rst[b]) begin
                armed[b] = 0; prev_rdy[b] = 1; prev_vld[b] = 0;
                continue;
            end
            samp[b]++;
            if (uart_ready[b] && !prev_rdy[b] && busy[b] && exp_q[b].size() > 0) begin
                armed[b]   = 1;
                rise_at[b] = samp[b];
            end
            if (uart_valid[b]) begin
                check("valid_single_cycle", b, 32'(prev_vld[b]), 0);
                if (exp_q[b].size() == 0) begin
                    check("unexpected_valid", b, 1, 0);
                end else begin
                    e = exp_q[b].pop_front();
                    check("uart_data", b, 32'(uart_data[b]), 32'(e & 255));
                    check("grant_id", b, 32'(grant_id[b]), 32'(e >> 8));
                end
                if (armed[b]) begin
                    check("gap_cycles", b, 32'(samp[b] - rise_at[b] - 1), 32'(gapc(b) + 1));
                    armed[b] = 0;
                end
            end
            prev_rdy[b] = uart_ready[b];
            prev_vld[b] = uart_valid[b];
        end
    end

    task automatic reset_mid_frame(input int b);
        logic [N*W-1:0] d = {8'hC3, 8'hB2, 8'hA1};
        wait_idle(b);
        hold[b]      = 1'b1;
        req_valid[b] = '1;
        req_data[b]  = d;
        @(negedge clk);
        req_valid[b] = '0;
        model_issue(b, model_pick(b, '1), d[model_pick(b, '1)*W +: W], 1'b0);
        hold[b] = 1'b0;
        wait_valid(b);
        repeat (4) @(negedge clk);
        check("t6_in_wait_done", b, 32'({busy[b], uart_ready[b]}), 32'(2'b10));
        #2 rst[b] = 1'b1;
        #1;
        check("t6_valid", b, 32'(uart_valid[b]), 0);
        check("t6_busy", b, 32'(busy[b]), 0);
        check("t6_req_ready", b, 32'(req_ready[b]), 7);
        check("t6_grant_id", b, 32'(grant_id[b]), N - 1);
        check("t6_sent", b, 32'(sent_count[b]), 0);
        m_last[b] = N - 1;
        m_sent[b] = 0;
        exp_q[b].delete();
        @(negedge clk);
        @(negedge clk);
        rst[b] = 1'b0;
        repeat (40) @(negedge clk);
        check("t6_discarded", b, 32'({busy[b], req_ready[b], sent_count[b]}), 32'({1'b0, 3'b111, 16'd0}));
    endtask

    initial begin
        int n;
        rst = 2'b11; stuck = 2'b00; hold = 2'b00;
        for (int b = 0; b < 2; b++) begin
            req_valid[b] = '0; req_data[b] = '0; m_last[b] = N - 1; m_sent[b] = 0;
        end
        repeat (3) @(negedge clk);
        for (int b = 0; b < 2; b++) begin
            check("rst_req_ready", b, 32'(req_ready[b]), 7);
            check("rst_outputs", b, 32'({uart_valid[b], busy[b], terr[b], uart_data[b]}), 0);
            check("rst_grant_id", b, 32'(grant_id[b]), N - 1);
            check("rst_sent", b, 32'(sent_count[b]), 0);
        end
        rst = 2'b00;
        @(negedge clk);

        // Single byte on slot 0: one-cycle latency to ISSUE, slot free afterwards.
        model_issue(0, model_pick(0, 3'b001), 8'h53, 1'b1);
        req_data[0]  = {16'h0000, 8'h53};
        req_valid[0] = 3'b001;
        @(negedge clk);
        check("t1_slot_held", 0, 32'(req_ready[0]), 32'(3'b110));
        check("t1_no_valid_yet", 0, 32'(uart_valid[0]), 0);
        req_valid[0] = '0;
        @(negedge clk);
        check("t1_valid", 0, 32'(uart_valid[0]), 1);
        @(negedge clk);
        check("t1_valid_drop", 0, 32'(uart_valid[0]), 0);
        check("t1_slot_free", 0, 32'(req_ready[0]), 7);
        wait_idle(0);
        check("t1_sent", 0, 32'(sent_count[0]), 32'(m_sent[0]));

        // Slots 1 and 2 held; slot 0 arrives mid-frame and jumps the queue next.
        wait_idle(0);
        hold[0]      = 1'b1;
        req_valid[0] = 3'b110;
        req_data[0]  = {8'h22, 8'h11, 8'h00};
        @(negedge clk);
        req_valid[0] = '0;
        n = model_pick(0, 3'b110);
        model_issue(0, n, req_data[0][n*W +: W], 1'b1);
        hold[0] = 1'b0;
        wait_valid(0);
        repeat (4) @(negedge clk);
        check("t3_in_transfer", 0, 32'({busy[0], uart_ready[0]}), 32'(2'b10));
        req_valid[0] = 3'b001;
        req_data[0]  = {8'h22, 8'h11, 8'h5A};
        @(negedge clk);
        req_valid[0] = '0;
        model_drain(0, (3'b110 & ~(3'(1) << n)) | 3'b001, req_data[0]);
        wait_idle(0);
        check("t3_sent", 0, 32'(sent_count[0]), 32'(m_sent[0]));

        // Fixed-order load on the round-robin arbiter, twice: A,B,C then A again.
        run_batch(1, 3'b111, {8'h43, 8'h42, 8'h41});
        run_batch(1, 3'b111, {8'h43, 8'h42, 8'h41});

        for (int b = 0; b < 2; b++) begin
            for (int it = 0; it < 15; it++) begin
                run_batch(b, 3'($urandom_range(1, 7)), 24'($urandom));
            end
        end

        // Serialiser never acknowledges: timeout, byte dropped, link still usable.
        wait_idle(0);
        stuck[0]     = 1'b1;
        req_valid[0] = 3'b100;
        req_data[0]  = {8'hA5, 16'h0000};
        model_issue(0, model_pick(0, 3'b100), 8'hA5, 1'b0);
        @(negedge clk);
        req_valid[0] = '0;
        wait_valid(0);
        n = 0;
        while (!terr[0] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t4_timeout_latency", 0, 32'(n), TO + 1);
        check("t4_back_to_idle", 0, 32'(busy[0]), 0);
        check("t4_sent_unchanged", 0, 32'(sent_count[0]), 32'(m_sent[0]));
        stuck[0] = 1'b0;
        run_batch(0, 3'b010, {8'h00, 8'h77, 8'h00});
        check("t4_sticky", 0, 32'(terr[0]), 1);

        reset_mid_frame(0);
        check("t6_timeout_cleared", 0, 32'(terr[0]), 0);
        reset_mid_frame(1);
        run_batch(1, 3'b111, {8'h33, 8'h22, 8'h11});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
